// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single data_mem between the CPU load/store port (0)
// and the loader/DMA port (1). Round-robin between simultaneous requests, one
// access in flight, and read data is registered per port so that neither
// requester ever observes the memory's floating read bus.
module data_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned MEM_AW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // port 0: CPU load/store stage
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic              err0,
   output logic [DATA_W-1:0] rdata0,
   // port 1: loader / DMA
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic              err1,
   output logic [DATA_W-1:0] rdata1,
   // data_mem side
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } state_e;

   state_e state;
   logic   rr_ptr;   // port that wins the next simultaneous request
   logic   win_id;   // port owning the access in flight
   logic   acc_err;  // in-flight access was out of range

   logic              grant_id;
   logic              grant_we;
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] grant_wdata;
   logic              grant_in_range;

   // Pick the winner among pending requests and mux its access fields.
   always_comb begin
      grant_id = 1'b0;
      if (req0 && req1) begin
         grant_id = rr_ptr;
      end else if (req1) begin
         grant_id = 1'b1;
      end
      grant_we       = grant_id ? we1    : we0;
      grant_addr     = grant_id ? addr1  : addr0;
      grant_wdata    = grant_id ? wdata1 : wdata0;
      // Only the low MEM_AW bits are backed by storage.
      grant_in_range = ((grant_addr >> MEM_AW) == '0);
   end

   // Arbitration FSM; all memory strobes and requester responses are registered here,
   // so an asynchronous reset clears them immediately (an interrupted write never commits).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         rr_ptr    <= 1'b0;
         win_id    <= 1'b0;
         acc_err   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               ack0 <= 1'b0;
               ack1 <= 1'b0;
               err0 <= 1'b0;
               err1 <= 1'b0;
               if (req0 || req1) begin
                  win_id    <= grant_id;
                  rr_ptr    <= ~grant_id;
                  mem_addr  <= grant_addr;
                  mem_wdata <= grant_wdata;
                  // Out-of-range accesses never touch the memory.
                  mem_read  <= grant_in_range & ~grant_we;
                  mem_write <= grant_in_range & grant_we;
                  acc_err   <= ~grant_in_range;
                  state     <= StAccess;
               end
            end

            StAccess: begin
               // Capture only while mem_read is high; the bus floats otherwise.
               if (mem_read) begin
                  if (win_id) begin
                     rdata1 <= mem_rdata;
                  end else begin
                     rdata0 <= mem_rdata;
                  end
               end
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               ack0      <= ~win_id;
               ack1      <= win_id;
               err0      <= ~win_id & acc_err;
               err1      <= win_id & acc_err;
               state     <= StDone;
            end

            StDone: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               err0  <= 1'b0;
               err1  <= 1'b0;
               state <= StIdle;
            end

            default: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               ack0      <= 1'b0;
               ack1      <= 1'b0;
               err0      <= 1'b0;
               err1      <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural data_mem behind it.
module tb_data_mem_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              clk;
   logic              rst_n;
   logic              req0, req1, we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1, err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_read, mem_write;
   wire  [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] mem [0:255];

   int checks = 0;
   int passes = 0;
   int overlap = 0;

   data_mem_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .MEM_AW(16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .we0      (we0),
      .addr0    (addr0),
      .wdata0   (wdata0),
      .ack0     (ack0),
      .err0     (err0),
      .rdata0   (rdata0),
      .req1     (req1),
      .we1      (we1),
      .addr1    (addr1),
      .wdata1   (wdata1),
      .ack1     (ack1),
      .err1     (err1),
      .rdata1   (rdata1),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_read (mem_read),
      .mem_write(mem_write),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural data_mem: combinational read, floating when not read, write on clock.
   assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : 'z;
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
   end

   always @(negedge clk) begin
      if (mem_read === 1'b1 && mem_write === 1'b1) overlap++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         passes++;
      end
   endtask

   // One access on port p; returns latency in cycles from the grant edge (-1 on timeout).
   task automatic access(input bit p, input logic we, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic e, output logic [31:0] rd,
                         output int nrd, output int nwr);
      @(negedge clk);
      if (!p) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
      lat = -1; e = 1'b0; rd = '0; nrd = 0; nwr = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mem_read) nrd++;
         if (mem_write) nwr++;
         if (p ? ack1 : ack0) begin
            lat = c;
            e   = p ? err1 : err0;
            rd  = p ? rdata1 : rdata0;
            break;
         end
      end
      if (!p) req0 = 1'b0;
      else req1 = 1'b0;
   endtask

   int          lat, nrd, nwr, n, cyc, cnt1;
   logic        e;
   logic [31:0] rd;
   int          order [8];
   int          ackcyc [8];
   logic [31:0] ackdat [8];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[2]  = 32'h0000_FFFF;
      mem[5]  = 32'h0000_0055;
      mem[20] = 32'hA0A0_0020;
      mem[21] = 32'hB1B1_0021;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ack0", {31'b0, ack0}, 32'd0);
      check("rst_ack1", {31'b0, ack1}, 32'd0);
      check("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      rst_n = 1'b1;

      // 1: single read on port 0
      access(1'b0, 1'b0, 32'd2, 32'd0, lat, e, rd, nrd, nwr);
      check("t1_latency", lat, 32'd2);
      check("t1_read_cycles", nrd, 32'd1);
      check("t1_write_cycles", nwr, 32'd0);
      check("t1_rdata0", rd, 32'h0000_FFFF);
      check("t1_err0", {31'b0, e}, 32'd0);

      // 2: write then read back on port 1
      access(1'b1, 1'b1, 32'd11, 32'hFFFF_0000, lat, e, rd, nrd, nwr);
      check("t2_wr_latency", lat, 32'd2);
      check("t2_wr_cycles", nwr, 32'd1);
      check("t2_mem11", mem[11], 32'hFFFF_0000);
      check("t2_wr_err1", {31'b0, e}, 32'd0);
      access(1'b1, 1'b0, 32'd11, 32'd0, lat, e, rd, nrd, nwr);
      check("t2_rd_latency", lat, 32'd2);
      check("t2_rdata1", rd, 32'hFFFF_0000);
      check("t2_rdata0_kept", rdata0, 32'h0000_FFFF);

      // 3: simultaneous held requests; last grant went to port 1 so port 0 leads
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd20;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'd21;
      n = 0; cyc = 0;
      while (n < 8 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (ack0 && ack1) check("t3_dual_ack", 32'd1, 32'd0);
         if (ack0 || ack1) begin
            order[n]  = ack1 ? 1 : 0;
            ackcyc[n] = cyc;
            ackdat[n] = ack1 ? rdata1 : rdata0;
            n++;
            if (n == 8) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      check("t3_ack_count", n, 32'd8);
      for (int i = 0; i < n; i++) begin
         check($sformatf("t3_order%0d", i), order[i], i % 2);
         check($sformatf("t3_rdata%0d", i), ackdat[i], (i % 2) ? 32'hB1B1_0021 : 32'hA0A0_0020);
         if (i > 0) check($sformatf("t3_gap%0d", i), ackcyc[i] - ackcyc[i-1], 32'd3);
      end

      // 4: out-of-range read on port 0
      access(1'b0, 1'b0, 32'h0001_0002, 32'd0, lat, e, rd, nrd, nwr);
      check("t4_latency", lat, 32'd2);
      check("t4_err0", {31'b0, e}, 32'd1);
      check("t4_no_access", nrd + nwr, 32'd0);
      check("t4_rdata0_kept", rd, 32'hA0A0_0020);

      // 6: port 0 held alone -> back-to-back grants every 3 cycles
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd2;
      n = 0; cyc = 0; cnt1 = 0;
      while (n < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (ack1) cnt1++;
         if (ack0) begin
            ackcyc[n] = cyc;
            n++;
            if (n == 4) req0 = 1'b0;
         end
      end
      req0 = 1'b0;
      check("t6_ack_count", n, 32'd4);
      for (int i = 0; i < n; i++) check($sformatf("t6_ack_cyc%0d", i), ackcyc[i], 2 + 3 * i);
      check("t6_no_ack1", cnt1, 32'd0);
      check("t6_rdata0", rdata0, 32'h0000_FFFF);

      // 5: reset during a write ACCESS
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'd7;
      @(posedge clk);
      #1;
      check("t5_write_on", {31'b0, mem_write}, 32'd1);
      rst_n = 1'b0;
      req0  = 1'b0;
      #1;
      check("t5_write_async_off", {31'b0, mem_write}, 32'd0);
      @(posedge clk);
      #1;
      check("t5_mem5_kept", mem[5], 32'h0000_0055);
      cnt1 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (ack0 || ack1) cnt1++;
      end
      check("t5_no_ack", cnt1, 32'd0);
      access(1'b0, 1'b0, 32'd5, 32'd0, lat, e, rd, nrd, nwr);
      check("t5_idle_latency", lat, 32'd2);
      check("t5_rdata0", rd, 32'h0000_0055);

      check("no_rw_overlap", overlap, 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
